// File: rtl/uart_pkg.sv
// Shared FSM encoding and constants for the memory-to-UART word sender.
// No logic here; defining UART_TX_CHECKSUM_EN adds the CSUM state to the enum.
// Imported by mem_uart_sender.
package uart_pkg;

   localparam int BYTES_PER_WORD       = 4;
   localparam int DEFAULT_CLKS_PER_BIT = 10417;

`ifdef UART_TX_CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_RD, ST_LAT, ST_LOAD, ST_SEND, ST_WAIT, ST_CSUM, ST_DONE
   } sender_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_RD, ST_LAT, ST_LOAD, ST_SEND, ST_WAIT, ST_DONE
   } sender_state_t;
`endif

endpackage

// File: rtl/mem_uart_sender_if.sv
// Bundle of control, memory-port and uart_tx-handshake signals of the sender.
// master = the sender itself, slave = the board top (memory, uart_tx, host).
// Pure wiring, no timing of its own.
interface mem_uart_sender_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic [ADDR_W-1:0] len;
   logic [ADDR_W-1:0] base;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata;
   logic              tx_dv;
   logic [7:0]        tx_byte;
   logic              tx_active;
   logic              tx_done;
   logic              busy;
   logic              done;

   modport master (
      input  start, len, base, mem_rdata, tx_active, tx_done,
      output mem_rd_en, mem_addr, tx_dv, tx_byte, busy, done
   );

   modport slave (
      output start, len, base, mem_rdata, tx_active, tx_done,
      input  mem_rd_en, mem_addr, tx_dv, tx_byte, busy, done
   );
endinterface

// File: rtl/byte_sel.sv
// Selects one byte of a 32-bit word, index 0 = least significant byte.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module byte_sel (
   input  logic [31:0] word,
   input  logic [1:0]  idx,
   output logic [7:0]  sel
);

   // LSB-first byte lane mux
   always_comb begin
      sel = word[7:0];
      case (idx)
         2'd1:    sel = word[15:8];
         2'd2:    sel = word[23:16];
         2'd3:    sel = word[31:24];
         default: sel = word[7:0];
      endcase
   end

endmodule

// File: rtl/mem_uart_sender.sv
// Streams len 32-bit words from a sync memory to uart_tx, 4 bytes/word LSB first.
// Latency: 4 cycles accept->first tx_dv, 2 cycles tx_done->next byte, 5 between words.
// Backpressure: waits on tx_active before each byte and on tx_done after it.
// Optional UART_TX_CHECKSUM_EN appends an 8-bit mod-256 sum of all bytes sent.
module mem_uart_sender
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int MEM_SIZE     = 64,
   parameter int ADDR_W       = 16
) (
   input logic               clk,
   input logic               rst,
   mem_uart_sender_if.master bus
);

   // CLKS_PER_BIT only configures the uart_tx wired next to this block;
   // a non-positive value is a board configuration error.
   if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
   end

   sender_state_t     state;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] word_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] len_clamped;
   logic [31:0]       word_q;
   logic [1:0]        idx_q;
   logic [7:0]        byte_q;
   logic [7:0]        sel_byte;
   logic              rd_en_q;
   logic              dv_q;
   logic              busy_q;
   logic              done_q;
`ifdef UART_TX_CHECKSUM_EN
   logic [7:0]        csum_q;
   logic              csum_sent;
`endif

   assign len_clamped = (bus.len > ADDR_W'(MEM_SIZE)) ? ADDR_W'(MEM_SIZE) : bus.len;

   byte_sel u_byte_sel (
      .word (word_q),
      .idx  (idx_q),
      .sel  (sel_byte)
   );

   assign bus.mem_rd_en = rd_en_q;
   assign bus.mem_addr  = addr_q;
   assign bus.tx_dv     = dv_q;
   assign bus.tx_byte   = byte_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   // Transfer sequencer; all outputs registered, strobes default low each cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         base_q   <= '0;
         len_q    <= '0;
         word_cnt <= '0;
         addr_q   <= '0;
         word_q   <= '0;
         idx_q    <= '0;
         byte_q   <= '0;
         rd_en_q  <= 1'b0;
         dv_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
         csum_q    <= '0;
         csum_sent <= 1'b0;
`endif
      end else begin
         rd_en_q <= 1'b0;
         dv_q    <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  base_q   <= bus.base;
                  len_q    <= len_clamped;
                  word_cnt <= '0;
                  idx_q    <= '0;
                  addr_q   <= bus.base;
                  // A zero-length request never touches memory
                  rd_en_q  <= (len_clamped != '0);
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
                  csum_q   <= '0;
`endif
                  state    <= ST_RD;
               end
            end
            ST_RD: begin
               if (len_q == '0) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  state  <= ST_LAT;
               end
            end
            ST_LAT: state <= ST_LOAD;
            ST_LOAD: begin
               word_q <= bus.mem_rdata;
               idx_q  <= '0;
               state  <= ST_SEND;
            end
            ST_SEND: begin
               if (!bus.tx_active) begin
                  byte_q <= sel_byte;
                  dv_q   <= 1'b1;
`ifdef UART_TX_CHECKSUM_EN
                  csum_q <= csum_q + sel_byte;
`endif
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.tx_done) begin
                  if (idx_q != 2'(BYTES_PER_WORD - 1)) begin
                     idx_q <= idx_q + 2'd1;
                     state <= ST_SEND;
                  end else if (word_cnt != len_q - ADDR_W'(1)) begin
                     word_cnt <= word_cnt + ADDR_W'(1);
                     addr_q   <= base_q + word_cnt + ADDR_W'(1);
                     rd_en_q  <= 1'b1;
                     state    <= ST_RD;
                  end else begin
`ifdef UART_TX_CHECKSUM_EN
                     csum_sent <= 1'b0;
                     state     <= ST_CSUM;
`else
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= ST_DONE;
`endif
                  end
               end
            end
`ifdef UART_TX_CHECKSUM_EN
            ST_CSUM: begin
               // First half sends the sum like a data byte, second half waits for its frame
               if (!csum_sent) begin
                  if (!bus.tx_active) begin
                     byte_q    <= csum_q;
                     dv_q      <= 1'b1;
                     csum_sent <= 1'b1;
                  end
               end else if (bus.tx_done) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= ST_DONE;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_uart_sender.sv
module tb_mem_uart_sender;

   localparam int ADDR_W   = 16;
   localparam int MEM_SIZE = 64;
   localparam int FRAME    = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_uart_sender_if #(.ADDR_W(ADDR_W)) bus ();

   mem_uart_sender #(
      .CLKS_PER_BIT (FRAME),
      .MEM_SIZE     (MEM_SIZE),
      .ADDR_W       (ADDR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [0:65535];
   int          cyc = 0;

   logic [15:0] rd_log[$];
   logic [7:0]  sent[$];
   int          dv_cyc[$];
   int          done_cyc[$];
   int          done_rise = -1;
   int          prot_err  = 0;
   logic        prev_dv   = 1'b0;
   logic        prev_done = 1'b0;

   logic [7:0]  exp_bytes[$];
   logic [15:0] exp_addrs[$];
   int          acc = 0;

   logic        u_active = 1'b0;
   int          u_cnt    = 0;
   logic [7:0]  u_byte   = 8'h00;
   logic        hold     = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous memory, data one cycle after the read strobe
   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_rdata <= mem[bus.mem_addr];
         rd_log.push_back(bus.mem_addr);
      end
   end

   // behavioural uart_tx: FRAME busy cycles per byte, done pulse as busy drops
   assign bus.tx_active = u_active | hold;
   always @(posedge clk) begin
      bus.tx_done <= 1'b0;
      if (u_active) begin
         if (u_cnt == FRAME - 1) begin
            u_active    <= 1'b0;
            bus.tx_done <= 1'b1;
         end else begin
            u_cnt <= u_cnt + 1;
         end
      end else if (bus.tx_dv) begin
         u_active <= 1'b1;
         u_cnt    <= 0;
         u_byte   <= bus.tx_byte;
         sent.push_back(bus.tx_byte);
      end
   end

   // protocol monitor and event timestamps
   always @(negedge clk) begin
      if (bus.tx_dv) begin
         dv_cyc.push_back(cyc);
         if (bus.tx_active) prot_err++;
         if (prev_dv) prot_err++;
      end
      if (bus.tx_done) done_cyc.push_back(cyc);
      if (bus.done && !prev_done) done_rise = cyc;
      if (u_active && bus.busy && bus.tx_byte !== u_byte) prot_err++;
      prev_dv   = bus.tx_dv;
      prev_done = bus.done;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: clamp, wrap addresses, LSB-first bytes, optional trailing sum
   task automatic build_expected(input logic [15:0] b, input logic [15:0] l);
      int n;
      logic [7:0] sum;
      exp_bytes.delete();
      exp_addrs.delete();
      n   = (int'(l) > MEM_SIZE) ? MEM_SIZE : int'(l);
      sum = 8'h00;
      for (int w = 0; w < n; w++) begin
         logic [15:0] a;
         logic [31:0] v;
         a = 16'(int'(b) + w);
         v = mem[a];
         exp_addrs.push_back(a);
         for (int k = 0; k < 4; k++) begin
            logic [7:0] by;
            by = 8'((v >> (8 * k)) & 32'hFF);
            exp_bytes.push_back(by);
            sum = sum + by;
         end
      end
`ifdef UART_TX_CHECKSUM_EN
      if (n > 0) exp_bytes.push_back(sum);
`endif
   endtask

   task automatic clear_logs();
      rd_log.delete();
      sent.delete();
      dv_cyc.delete();
      done_cyc.delete();
      done_rise = -1;
      prot_err  = 0;
   endtask

   task automatic start_xfer(input logic [15:0] b, input logic [15:0] l);
      @(negedge clk);
      clear_logs();
      build_expected(b, l);
      @(negedge clk);
      bus.base  = b;
      bus.len   = l;
      bus.start = 1'b1;
      acc       = cyc + 1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.base  = 16'($urandom);
      bus.len   = 16'($urandom);
   endtask

   task automatic wait_dv(input int n);
      for (int i = 0; i < 2000 && dv_cyc.size() < n; i++) @(negedge clk);
      check("wait_dv", 64'(dv_cyc.size() >= n), 1);
   endtask

   task automatic finish_xfer(input bit timing);
      int bad;
      int nw;
      for (int i = 0; i < 20000 && !bus.done; i++) @(negedge clk);
      @(negedge clk);
      check("done_set", bus.done, 1);
      check("busy_clear", bus.busy, 0);
      check("byte_count", sent.size(), exp_bytes.size());
      for (int k = 0; k < sent.size() && k < exp_bytes.size(); k++)
         check($sformatf("byte%0d", k), sent[k], exp_bytes[k]);
      check("rd_count", rd_log.size(), exp_addrs.size());
      for (int k = 0; k < rd_log.size() && k < exp_addrs.size(); k++)
         check($sformatf("rd_addr%0d", k), rd_log[k], exp_addrs[k]);
      check("done_pulses", done_cyc.size(), exp_bytes.size());
      check("protocol", prot_err, 0);
      if (timing && exp_bytes.size() > 0 && dv_cyc.size() == exp_bytes.size()
          && done_cyc.size() == exp_bytes.size()) begin
         nw  = exp_addrs.size();
         bad = 0;
         check("first_dv_latency", dv_cyc[0] - acc, 4);
         for (int k = 1; k < dv_cyc.size(); k++)
            if (dv_cyc[k] - done_cyc[k-1] != (((k % 4) == 0 && k < 4 * nw) ? 5 : 2)) bad++;
         check("byte_gaps", bad, 0);
         check("done_latency", done_rise - done_cyc[done_cyc.size()-1], 1);
      end
   endtask

   initial begin
      int rel;
      int ndv;
      int nrd;

      for (int a = 0; a < 65536; a++) mem[a] = $urandom;
      mem[0] = 32'h4433_2211;
      mem[1] = 32'h8877_6655;
      mem[16'h0020] = 32'h0102_0304;
      bus.start = 1'b0;
      bus.len   = '0;
      bus.base  = '0;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_mem_rd_en", bus.mem_rd_en, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_tx_dv", bus.tx_dv, 0);
      check("rst_tx_byte", bus.tx_byte, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      rst = 1'b0;

      // two known words, LSB first
      start_xfer(16'h0000, 16'd2);
      check("busy_after_start", bus.busy, 1);
      finish_xfer(1);
      for (int k = 0; k < 8; k++)
         check($sformatf("known_byte%0d", k), (sent.size() > k) ? sent[k] : 8'h00, 8'((k + 1) * 8'h11));
      check("known_rd0", (rd_log.size() > 0) ? rd_log[0] : 16'hFFFF, 16'h0000);
      check("known_rd1", (rd_log.size() > 1) ? rd_log[1] : 16'hFFFF, 16'h0001);

      // zero length
      @(negedge clk);
      clear_logs();
      bus.base  = 16'h0005;
      bus.len   = 16'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("len0_done_early", bus.done, 0);
      check("len0_busy", bus.busy, 1);
      @(negedge clk);
      check("len0_done", bus.done, 1);
      check("len0_busy_clear", bus.busy, 0);
      repeat (5) @(negedge clk);
      check("len0_no_dv", dv_cyc.size(), 0);
      check("len0_no_rd", rd_log.size(), 0);

      // length clamp
      start_xfer(16'h0000, 16'd100);
      finish_xfer(1);
      check("clamp_last_addr", (rd_log.size() == 64) ? rd_log[63] : 16'hFFFF, 16'd63);

      // random transfers, including an address wrap
      for (int t = 0; t < 4; t++) begin
         start_xfer(16'($urandom), 16'($urandom_range(1, 5)));
         finish_xfer(1);
      end
      start_xfer(16'hFFFE, 16'd3);
      finish_xfer(1);

      // start ignored while busy, tx_active held high before byte 1
      start_xfer(16'h0010, 16'd3);
      wait_dv(1);
      hold = 1'b1;
      @(negedge clk);
      bus.base  = 16'h0300;
      bus.len   = 16'd7;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("hold_busy", bus.busy, 1);
      repeat (50) @(negedge clk);
      check("hold_no_dv", dv_cyc.size(), 1);
      rel  = cyc;
      hold = 1'b0;
      wait_dv(2);
      check("release_latency", (dv_cyc.size() > 1) ? dv_cyc[1] - rel : -1, 1);
      finish_xfer(0);

      // reset mid-transfer with a stale tx_done afterwards
      start_xfer(16'h0040, 16'd2);
      wait_dv(3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_mem_rd_en", bus.mem_rd_en, 0);
      check("abort_mem_addr", bus.mem_addr, 0);
      check("abort_tx_dv", bus.tx_dv, 0);
      check("abort_tx_byte", bus.tx_byte, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      ndv = dv_cyc.size();
      nrd = rd_log.size();
      for (int i = 0; i < 100 && u_active; i++) @(negedge clk);
      repeat (6) @(negedge clk);
      check("stale_done_seen", done_cyc.size(), 3);
      check("abort_no_more_dv", dv_cyc.size(), ndv);
      check("abort_no_more_rd", rd_log.size(), nrd);
      check("abort_idle_busy", bus.busy, 0);
      check("abort_idle_done", bus.done, 0);
      start_xfer(16'h0040, 16'd2);
      finish_xfer(1);

      // single word, checksum build appends the sum
      start_xfer(16'h0020, 16'd1);
      finish_xfer(1);
      check("csum_word_b0", (sent.size() > 0) ? sent[0] : 8'h00, 8'h04);
`ifdef UART_TX_CHECKSUM_EN
      check("csum_byte", (sent.size() > 4) ? sent[4] : 8'h00, 8'h0A);
`else
      check("no_extra_byte", sent.size(), 4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_uart_sender.md
# mem_uart_sender

Memory-to-UART word streamer for the knapsack board. On a start pulse it reads a programmed number of 32-bit words from a synchronous memory port and feeds them, 4 bytes per word and LSB first, to a `uart_tx` instance. It paces itself with the transmitter's handshake rather than a fixed byte timer. It is the transmit-side counterpart of the host-to-memory word loader: the same byte order and word format, in the opposite direction.

## Interface
Parameters:
- `CLKS_PER_BIT`, 10417: passed through to the `uart_tx` instance (100 MHz / 9600 baud); not used internally.
- `MEM_SIZE`, 64: maximum number of words per transfer; `len` values above this are clamped to it.
- `ADDR_W`, 16: width of the memory address and of `len`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE or DONE.
- `len`  in  ADDR_W  number of words to send; latched on an accepted `start`.
- `base`  in  ADDR_W  first word address; latched on an accepted `start`.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  memory word address.
- `mem_rdata`  in  32  read data, valid exactly 1 cycle after `mem_rd_en`.
- `tx_dv`  out  1  one-cycle byte-valid pulse to `uart_tx`.
- `tx_byte`  out  8  byte to `uart_tx`; held stable from `tx_dv` until `tx_done`.
- `tx_active`  in  1  `uart_tx` busy flag.
- `tx_done`  in  1  `uart_tx` one-cycle frame-complete pulse.
- `busy`  out  1  high from an accepted `start` until entry to DONE.
- `done`  out  1  sticky completion flag; cleared by the next accepted `start` or by `rst`.

## Operation
- FSM states: IDLE, RD, LAT, LOAD, SEND, WAIT, (CSUM), DONE.
- IDLE/DONE → RD on `start`:
  - latch `base`, and latch `len` clamped to `MEM_SIZE`;
  - clear the word counter, the byte index and the checksum;
  - set `busy`, clear `done`.
  - If the latched length is 0, go directly to DONE. No bytes are sent in either build.
- RD: assert `mem_rd_en` with `mem_addr` = base + word counter. Go to LAT.
- LAT: latency cycle. Go to LOAD.
- LOAD: capture `mem_rdata` into the word register. Set byte index to 0. Go to SEND.
- SEND: when `tx_active`=0, drive `tx_byte` = word[8*idx+7:8*idx] and pulse `tx_dv`. Go to WAIT. If `tx_active`=1, stay in SEND.
- WAIT: on `tx_done`:
  - idx < 3: increment idx and go to SEND;
  - idx = 3 and words remain: increment the word counter and go to RD;
  - last word: go to CSUM if `UART_TX_CHECKSUM_EN` is defined, otherwise go to DONE.
- DONE: `busy`=0, `done`=1. A new `start` restarts the FSM.
- `start` during `busy` is ignored. `len`/`base` changes after acceptance have no effect.
- A `tx_done` arriving in any state other than WAIT/CSUM-wait is ignored. This covers a frame left running by a mid-operation reset.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
- Reset values:
  - `mem_rd_en`, `tx_dv`, `busy`, `done`: 0;
  - `mem_addr`, `tx_byte`: 0;
  - FSM in IDLE.
- `rst` mid-transfer aborts immediately. No further `tx_dv` is issued.
- Latency from `start` to the first `tx_dv` is 4 cycles (RD, LAT, LOAD, SEND), provided `tx_active`=0.
- Between consecutive bytes of a word: `tx_dv` follows `tx_done` by 2 cycles.
- Between words: `tx_done` of byte 3 to the next `tx_dv` is 5 cycles.
- `done` rises 1 cycle after the final `tx_done`.
- `tx_dv` is never asserted while `tx_active`=1 and is never high for 2 consecutive cycles.

## Configuration
- `UART_TX_CHECKSUM_EN` defined:
  - an 8-bit running sum (mod 256) of every byte sent is kept;
  - after the last data byte, CSUM sends the checksum as one extra byte with the same dv/done handshake, then goes to DONE.
- Not defined: there is no CSUM state and no checksum register. The transfer is exactly 4·len bytes.

## Structure
- The shared package `uart_pkg` holds:
  - the FSM state enum `sender_state_t`;
  - the constant `BYTES_PER_WORD` = 4;
  - `DEFAULT_CLKS_PER_BIT` = 10417.
- The block is a single module and does not instantiate `uart_tx`. The top level wires `uart_tx` and `mem` to it.
- One natural sub-module, `byte_sel`: a 32→8 mux indexed by the byte index. It is optional and purely combinational.

## Test plan
- Words 0x44332211 and 0x88776655 at base 0, `len`=2, behavioural `uart_tx` model → bytes 11 22 33 44 55 66 77 88 in order; `done`=1 after the 8th `tx_done`; exactly 2 `mem_rd_en` pulses, at addresses 0 and 1.
- `len`=0 → no `tx_dv`, no `mem_rd_en`; `done`=1 two cycles after `start`.
- `len`=100 with `MEM_SIZE`=64 → exactly 256 bytes sent; last address read is 63.
- `start` re-pulsed mid-transfer and `tx_active` held high 50 cycles before byte 1 → second `start` ignored; `tx_dv` withheld until `tx_active` falls; byte order intact.
- `rst` asserted after byte 2 of word 0, then a stale `tx_done` → all outputs 0, FSM stays in IDLE, and a fresh `start` sends from byte 0 of `base`.
- With `UART_TX_CHECKSUM_EN`: word 0x01020304, `len`=1 → bytes 04 03 02 01 then 0x0A; `done` follows the 5th `tx_done`.
